mem_arbiter: RTL

- Shares one single-port unified memory between the instruction-fetch (IF) requester and the data-access (MEM) requester of the 5-stage pipeline.
- Sequences each memory transaction through a request/ack handshake, with a timeout counter guarding each one.
- Generates the stall signals the pipeline registers use while a requester waits.
- Data accesses have priority, and a starvation guard keeps fetch from being locked out.

---
 rtl/mem_arbiter_if.sv | 46 ++++
 rtl/mem_arbiter.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// Purpose: bundles the IF requester, MEM requester and memory-side signals of the memory arbiter.
// Latency: none, wiring only.
// Backpressure: none, the request/ready and en/ack handshakes are carried as-is.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // fetch requester
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ready;
    // data requester
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ready;
    // single-port memory
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;
    // pipeline status
    logic              stall_if;
    logic              stall_mem;
    logic              err;
    logic              owner;

    // arbiter view
    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
        output if_rdata, if_ready, d_rdata, d_ready, mem_en, mem_we, mem_addr, mem_wdata,
               stall_if, stall_mem, err, owner
    );

    // requesters plus memory view
    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
        input  if_rdata, if_ready, d_rdata, d_ready, mem_en, mem_we, mem_addr, mem_wdata,
               stall_if, stall_mem, err, owner
    );
endinterface

// File: rtl/mem_arbiter.sv
// Purpose: shares one single-port memory between fetch and data requesters, data first with a fetch starvation guard.
// Latency: request sampled in IDLE -> mem_en next cycle -> ready one cycle after ack; 3-cycle minimum period.
// Backpressure: requesters stall until their ready pulse; a missing ack ends in an err completion after TIMEOUT WAIT cycles.
module mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int TIMEOUT    = 15,
    parameter int STARVE_MAX = 4
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_q,     state_nxt;
    logic [TW-1:0]     to_q,        to_nxt;
    logic [SW-1:0]     starve_q,    starve_nxt;
    logic              mem_en_q,    mem_en_nxt;
    logic              mem_we_q,    mem_we_nxt;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_nxt;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_nxt;
    logic              owner_q,     owner_nxt;
    logic [DATA_W-1:0] if_rdata_q,  if_rdata_nxt;
    logic [DATA_W-1:0] d_rdata_q,   d_rdata_nxt;
    logic              if_ready_q,  if_ready_nxt;
    logic              d_ready_q,   d_ready_nxt;
    logic              err_q,       err_nxt;
    logic              grant_d;

    // Next-state and next-output logic: arbitration in IDLE, ack/timeout in WAIT, single ready cycle in RESP.
    always_comb begin
        state_nxt     = state_q;
        to_nxt        = to_q;
        starve_nxt    = starve_q;
        mem_en_nxt    = 1'b0;
        mem_we_nxt    = mem_we_q;
        mem_addr_nxt  = mem_addr_q;
        mem_wdata_nxt = mem_wdata_q;
        owner_nxt     = owner_q;
        if_rdata_nxt  = if_rdata_q;
        d_rdata_nxt   = d_rdata_q;
        if_ready_nxt  = 1'b0;
        d_ready_nxt   = 1'b0;
        err_nxt       = 1'b0;
        // data wins unless fetch is also waiting and has been passed over STARVE_MAX times
        grant_d       = bus.d_req & (~bus.if_req | (starve_q < SW'(STARVE_MAX)));

        unique case (state_q)
            IDLE: begin
                if (bus.d_req | bus.if_req) begin
                    state_nxt  = WAIT;
                    mem_en_nxt = 1'b1;
                    to_nxt     = '0;
                    if (grant_d) begin
                        owner_nxt     = 1'b1;
                        mem_we_nxt    = bus.d_we;
                        mem_addr_nxt  = bus.d_addr;
                        mem_wdata_nxt = bus.d_wdata;
                        if (!bus.if_req) begin
                            starve_nxt = '0;
                        end else if (starve_q < SW'(STARVE_MAX)) begin
                            starve_nxt = starve_q + SW'(1);
                        end
                    end else begin
                        owner_nxt     = 1'b0;
                        mem_we_nxt    = 1'b0;
                        mem_addr_nxt  = bus.if_addr;
                        mem_wdata_nxt = '0;
                        starve_nxt    = '0;
                    end
                end
            end
            WAIT: begin
                if (bus.mem_ack || (to_q == TW'(TIMEOUT - 1))) begin
                    // an ack on the final WAIT cycle still counts as a normal completion
                    state_nxt = RESP;
                    err_nxt   = ~bus.mem_ack;
                    if (!bus.mem_ack) begin
                        to_nxt = to_q + TW'(1);
                    end
                    if (owner_q) begin
                        d_ready_nxt = 1'b1;
                        // stores leave the load data register untouched
                        if (!mem_we_q) begin
                            d_rdata_nxt = bus.mem_ack ? bus.mem_rdata : '0;
                        end
                    end else begin
                        if_ready_nxt = 1'b1;
                        if_rdata_nxt = bus.mem_ack ? bus.mem_rdata : '0;
                    end
                end else begin
                    to_nxt = to_q + TW'(1);
                end
            end
            RESP: begin
                to_nxt    = '0;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset abandons any transaction in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            to_q        <= '0;
            starve_q    <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            owner_q     <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_ready_q  <= 1'b0;
            d_ready_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_nxt;
            to_q        <= to_nxt;
            starve_q    <= starve_nxt;
            mem_en_q    <= mem_en_nxt;
            mem_we_q    <= mem_we_nxt;
            mem_addr_q  <= mem_addr_nxt;
            mem_wdata_q <= mem_wdata_nxt;
            owner_q     <= owner_nxt;
            if_rdata_q  <= if_rdata_nxt;
            d_rdata_q   <= d_rdata_nxt;
            if_ready_q  <= if_ready_nxt;
            d_ready_q   <= d_ready_nxt;
            err_q       <= err_nxt;
        end
    end

    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.owner     = owner_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.if_ready  = if_ready_q;
    assign bus.d_ready   = d_ready_q;
    assign bus.err       = err_q;
    assign bus.stall_if  = bus.if_req & ~if_ready_q;
    assign bus.stall_mem = bus.d_req & ~d_ready_q;

endmodule
